pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports RA1D, RA2D  input  4 each  source register numbers of the instruction in Decode.
REQ-005 SHALL have ports RA1E, RA2E  input  4 each  source register numbers of the instruction in Execute.
REQ-006 SHALL have ports WA3E, WA3M, WA3W  input  4 each  destination register numbers in Execute, Memory and Writeback.
REQ-007 SHALL have ports RegWriteE, RegWriteM, RegWriteW, MemToRegE  input  1 each  write-enable and load flags per stage.
REQ-008 SHALL have ports PCSrcD, PCSrcE  input  1 each  instruction in Decode or Execute writes R15.
REQ-009 SHALL have port BranchTakenE  input  1  branch resolved taken in Execute.
REQ-010 SHALL have ports ForwardAE, ForwardBE  output  2 each  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-011 SHALL have ports StallF, StallD, FlushD, FlushE  output  1 each  hold or clear controls for the Fetch/Decode and Decode/Execute pipe registers.
REQ-012 SHALL have ports stallCount, flushCount  output  CNT_W each  saturating event counters.

Function
REQ-013 SHALL drive ForwardAE to 10 when RegWriteM=1, WA3M=RA1E and RA1E!=15; else to 01 when RegWriteW=1, WA3W=RA1E and RA1E!=15; else to 00. Memory has priority over Writeback.
REQ-014 SHALL compute ForwardBE by the same rule using RA2E.
REQ-015 SHALL compute ldHaz = MemToRegE & RegWriteE & (WA3E=RA1D | WA3E=RA2D), combinationally.
REQ-016 SHALL implement FSM states RUN and PCWAIT, plus a 2-bit down-counter pcCnt.
REQ-017 In RUN with BranchTakenE=1, SHALL assert FlushD=1 and FlushE=1 and StallF=StallD=0; branch overrides ldHaz and PCSrcD in the same cycle; next state RUN.
REQ-018 In RUN with ldHaz=1 and no branch, SHALL assert StallF=1, StallD=1 and FlushE=1 (one bubble); next state RUN.
REQ-019 In RUN with PCSrcD=1, no branch and no ldHaz, SHALL assert StallF=1 and FlushD=1; next state PCWAIT with pcCnt=2.
REQ-020 In PCWAIT with pcCnt=2 and PCSrcE=0 (condition failed), SHALL drive no stall or flush and return to RUN.
REQ-021 In PCWAIT with pcCnt!=0, SHALL assert StallF=1 and FlushD=1 and decrement pcCnt.
REQ-022 In PCWAIT with pcCnt=0 (Writeback cycle), SHALL assert FlushD=1 only, StallF=0, and return to RUN.
REQ-023 In PCWAIT, BranchTakenE=1 SHALL additionally assert FlushE without changing state or pcCnt.
REQ-024 SHALL increment stallCount by 1 in each cycle with StallF=1, saturating at all-ones.
REQ-025 SHALL increment flushCount by 1 in each cycle with FlushD|FlushE=1, saturating at all-ones.
REQ-026 Outputs in REQ-013..REQ-023 SHALL be combinational from the current state and inputs, with zero-cycle latency.

Reset
REQ-027 While rst=0: state=RUN, pcCnt=0, stallCount=0, flushCount=0 asynchronously; stall and flush outputs are then those of RUN with current inputs.
REQ-028 Reset asserted mid-PCWAIT SHALL abandon the sequence; the first cycle after release is RUN.

Structure
REQ-029 The state enum, forwarding-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the PC register constant 15 SHALL live in the shared pipeline package.
REQ-030 SHALL instantiate sub-module hazard_event_counter twice (saturating counter with parameter CNT_W, inputs clk, rst and inc).

Verification
REQ-031 The bench SHALL cover: RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10; with RA1E=15 instead -> ForwardAE=00.
REQ-032 The bench SHALL cover: MemToRegE=RegWriteE=1, WA3E=5, RA2D=5 -> one cycle of StallF=StallD=FlushE=1; stallCount goes 0->1.
REQ-033 The bench SHALL cover: PCSrcD pulse, then PCSrcE=1 -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles, then RUN.
REQ-034 The bench SHALL cover: PCSrcD pulse, then PCSrcE=0 -> exactly one cycle of StallF and FlushD, then RUN.
REQ-035 The bench SHALL cover: BranchTakenE=1 together with ldHaz=1 -> FlushD=FlushE=1 and StallF=0.
REQ-036 The bench SHALL cover: preload the counter to all-ones via 2^CNT_W stall cycles with CNT_W=4 -> stallCount holds 15; rst low mid-PCWAIT -> RUN and counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   hz_state_t    : controller FSM states
//   fwd_sel_t     : Execute-stage operand select encodings
//   PC_REG        : architectural register number of the program counter
//   fwd_select()  : forwarding-select helper (Memory beats Writeback, R15 never forwarded)
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN,
    ST_PCWAIT
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] PC_REG = 4'd15;

  function automatic fwd_sel_t fwd_select(
    input logic       reg_write_m,
    input logic [3:0] wa3m,
    input logic       reg_write_w,
    input logic [3:0] wa3w,
    input logic [3:0] ra
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (reg_write_m && (wa3m == ra))      sel = FWD_MEM;
      else if (reg_write_w && (wa3w == ra)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_counter.sv
// Saturating event counter used for stall/flush statistics.
//   clk   : system clock
//   rst   : asynchronous active-low reset, clears count
//   inc   : count one event this cycle
//   count : current event count, sticks at all-ones
module hazard_event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall,
// branch flush and the PC-write (R15 destination) wait sequence, plus
// saturating stall/flush event counters.
//   clk, rst                     : clock, asynchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E         : source registers in Decode / Execute
//   WA3E/WA3M/WA3W               : destination registers in Execute/Memory/Writeback
//   RegWriteE/M/W, MemToRegE     : per-stage write enables and load flag
//   PCSrcD/PCSrcE                : instruction in Decode/Execute writes R15
//   BranchTakenE                 : branch resolved taken in Execute
//   ForwardAE/ForwardBE          : Execute operand selects
//   StallF/StallD/FlushD/FlushE  : pipe-register hold/clear controls (combinational)
//   stallCount/flushCount        : saturating event counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  hz_state_t  state;
  logic [1:0] pcCnt;
  logic       ldHaz;

  always_comb begin
    ForwardAE = fwd_select(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
    ForwardBE = fwd_select(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
  end

  assign ldHaz = MemToRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // pcCnt counts down 2 -> 1 -> 0 while the R15 write travels Execute ->
  // Memory -> Writeback; at pcCnt=2 a failed condition (PCSrcE=0) aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      pcCnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!BranchTakenE && !ldHaz && PCSrcD) begin
            state <= ST_PCWAIT;
            pcCnt <= 2'd2;
          end
        end
        ST_PCWAIT: begin
          if ((pcCnt == 2'd2) && !PCSrcE) begin
            state <= ST_RUN;
            pcCnt <= '0;
          end else if (pcCnt != '0) begin
            pcCnt <= pcCnt - 2'd1;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          pcCnt <= '0;
        end
      endcase
    end
  end

  // Controls are decoded from the current state with zero latency so the
  // pipe registers react in the same cycle the hazard is visible.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    case (state)
      ST_RUN: begin
        if (BranchTakenE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (ldHaz) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (PCSrcD) begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end
      end
      ST_PCWAIT: begin
        if ((pcCnt == 2'd2) && !PCSrcE) begin
          StallF = 1'b0;
        end else if (pcCnt != '0) begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end else begin
          FlushD = 1'b1;
        end
        if (BranchTakenE) FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (stallCount)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (FlushD | FlushE),
    .count (flushCount)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic             PCSrcD, PCSrcE, BranchTakenE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] stallCount, flushCount;

  int checks = 0;
  int failures = 0;

  // Reference model: age of the PC-write sequence in cycles since the
  // PCSrcD cycle (0 = none pending), and integer event tallies.
  int m_age, m_stall, m_flush, nxt_age;
  bit e_sf, e_sd, e_fd, e_fe;
  bit s_sf, s_sd, s_fd, s_fe;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic rwm, input logic [3:0] wm,
                                         input logic rww, input logic [3:0] ww,
                                         input logic [3:0] ra);
    if (ra == 4'd15)           return 2'b00;
    if (rwm && (wm == ra))     return 2'b10;
    if (rww && (ww == ra))     return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit ld;
    ld = MemToRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
    e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
    nxt_age = m_age;
    if (m_age == 0) begin
      if (BranchTakenE) begin
        e_fd = 1; e_fe = 1;
      end else if (ld) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end else if (PCSrcD) begin
        e_sf = 1; e_fd = 1; nxt_age = 1;
      end
    end else begin
      if (m_age == 1 && !PCSrcE) begin
        nxt_age = 0;
      end else if (m_age < 3) begin
        e_sf = 1; e_fd = 1; nxt_age = m_age + 1;
      end else begin
        e_fd = 1; nxt_age = 0;
      end
      if (BranchTakenE) e_fe = 1;
    end
  endtask

  // One clock cycle: inputs already applied; compare at the falling edge,
  // advance the model at the rising edge, return 1 time unit later.
  task automatic step();
    if (!rst) begin m_age = 0; m_stall = 0; m_flush = 0; end
    @(negedge clk);
    model_eval();
    chk("ForwardAE", ForwardAE, ref_fwd(RegWriteM, WA3M, RegWriteW, WA3W, RA1E));
    chk("ForwardBE", ForwardBE, ref_fwd(RegWriteM, WA3M, RegWriteW, WA3W, RA2E));
    chk("StallF", StallF, e_sf);
    chk("StallD", StallD, e_sd);
    chk("FlushD", FlushD, e_fd);
    chk("FlushE", FlushE, e_fe);
    chk("stallCount", stallCount, m_stall);
    chk("flushCount", flushCount, m_flush);
    s_sf = StallF; s_sd = StallD; s_fd = FlushD; s_fe = FlushE;
    @(posedge clk);
    if (rst) begin
      if (e_sf && m_stall < CMAX) m_stall++;
      if ((e_fd || e_fe) && m_flush < CMAX) m_flush++;
      m_age = nxt_age;
    end else begin
      m_age = 0; m_stall = 0; m_flush = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0;
    PCSrcD = 0; PCSrcE = 0; BranchTakenE = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_stallCount", stallCount, 0);
    chk("rst_flushCount", flushCount, 0);
    step();
    rst = 1;
  endtask

  function automatic logic [3:0] pick_reg();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  int n_sf, n_fd;

  initial begin
    rst = 0;
    clear_inputs();
    m_age = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    do_reset();

    // load-use stall: exactly one bubble, stall counter 0 -> 1
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
    step();
    chk("ldhaz_StallF", s_sf, 1);
    chk("ldhaz_StallD", s_sd, 1);
    chk("ldhaz_FlushE", s_fe, 1);
    chk("ldhaz_cnt1", stallCount, 1);
    clear_inputs();
    step();
    chk("ldhaz_release", s_sf, 0);

    // forwarding priority and R15 exclusion
    RegWriteM = 1; WA3M = 3; RA1E = 3; RegWriteW = 1; WA3W = 3;
    #2 chk("fwdA_mem_prio", ForwardAE, 2'b10);
    RA1E = 15;
    #2 chk("fwdA_r15", ForwardAE, 2'b00);
    RegWriteM = 0; RA1E = 3;
    #2 chk("fwdA_wb", ForwardAE, 2'b01);
    step();
    clear_inputs();

    // PC write, condition passed: StallF x3, FlushD x4
    PCSrcD = 1; step();
    n_sf = s_sf; n_fd = s_fd;
    PCSrcD = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      step(); n_sf += s_sf; n_fd += s_fd;
    end
    chk("pcw_pass_stalls", n_sf, 3);
    chk("pcw_pass_flushes", n_fd, 4);
    PCSrcE = 0; step();
    chk("pcw_pass_run", {s_sf, s_fd}, 2'b00);

    // PC write, condition failed: one cycle of StallF/FlushD
    PCSrcD = 1; step();
    n_sf = s_sf; n_fd = s_fd;
    PCSrcD = 0; PCSrcE = 0;
    for (int i = 0; i < 3; i++) begin
      step(); n_sf += s_sf; n_fd += s_fd;
    end
    chk("pcw_fail_stalls", n_sf, 1);
    chk("pcw_fail_flushes", n_fd, 1);

    // branch overrides load-use and PCSrcD
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5; BranchTakenE = 1; PCSrcD = 1;
    step();
    chk("br_FlushD", s_fd, 1);
    chk("br_FlushE", s_fe, 1);
    chk("br_StallF", s_sf, 0);
    clear_inputs();
    step();
    chk("br_no_pcwait", s_fd, 0);

    // saturation: 16 stall cycles on a 4-bit counter
    do_reset();
    MemToRegE = 1; RegWriteE = 1; WA3E = 7; RA1D = 7;
    for (int i = 0; i < 16; i++) step();
    chk("sat_stall_15", stallCount, 15);
    step();
    chk("sat_stall_hold", stallCount, 15);
    clear_inputs();

    // reset mid-PCWAIT abandons the sequence
    PCSrcD = 1; step();
    PCSrcD = 0; PCSrcE = 1; step();
    rst = 0;
    #1;
    chk("midrst_stallCount", stallCount, 0);
    chk("midrst_flushCount", flushCount, 0);
    chk("midrst_StallF", StallF, 0);
    step();
    rst = 1;
    step();
    chk("midrst_run_StallF", s_sf, 0);
    chk("midrst_run_FlushD", s_fd, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      RA1D = pick_reg(); RA2D = pick_reg(); RA1E = pick_reg(); RA2E = pick_reg();
      WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg();
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemToRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 5) == 0);
      PCSrcE = 1'($urandom_range(0, 1));
      BranchTakenE = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 59) != 0);
      step();
    end
    rst = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
